// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared constants and helpers for the PE row result drain
package pe_array_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // LSB position of PE k inside the concatenated pe_results bus
  function automatic int pe_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/drain_shadow_bank.sv
// rtl/drain_shadow_bank.sv - snapshot registers for one PE row with an indexed read mux
module drain_shadow_bank
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_PE     = 4,
  parameter int IDX_W      = $clog2(NUM_PE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [NUM_PE*DATA_WIDTH-1:0] load_data,
  input  logic [IDX_W-1:0]             rd_index,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] bank [NUM_PE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_PE; k++) bank[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_PE; k++) bank[k] <= load_data[pe_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  assign rd_data = bank[rd_index];

endmodule

// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - snapshots a PE row on start and streams it out one beat per element
module pe_result_drain
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_PE     = 4,
  parameter int IDX_W      = $clog2(NUM_PE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_results,
  output logic                         pe_clear,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]             out_index,
  output logic                         out_last,
  output logic                         done
);

  logic [1:0]            state;
  logic [IDX_W-1:0]      index;
  logic                  load;
  logic                  at_last;
  logic [DATA_WIDTH-1:0] rd_data;

  assign load    = (state == ST_IDLE) && start;
  assign at_last = (index == IDX_W'(NUM_PE - 1));

  drain_shadow_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_PE     (NUM_PE),
    .IDX_W      (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (pe_results),
    .rd_index  (index),
    .rd_data   (rd_data)
  );

  // pe_clear is registered off the accepted start so the row zeroes one cycle after the snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      index    <= '0;
      pe_clear <= 1'b0;
    end else begin
      pe_clear <= load;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SEND;
            index <= '0;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (at_last) state <= ST_DONE;
            else         index <= index + IDX_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Beat fields are forced to zero outside SEND so idle outputs match the reset values
  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_last  = out_valid && at_last;
  assign out_data  = out_valid ? rd_data : '0;
  assign out_index = out_valid ? index : '0;

endmodule

// File: tb/tb_pe_result_drain.sv
// tb/tb_pe_result_drain.sv - directed bench with a queue-based drain model and literal checks
module tb_pe_result_drain;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NP*DW-1:0] pe_results = '0;
  logic          pe_clear, busy, out_valid, out_ready = 1'b0, out_last, done;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;

  pe_result_drain #(.DATA_WIDTH(DW), .NUM_PE(NP), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .pe_results(pe_results),
    .pe_clear(pe_clear), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 sending, 2 done; pending beats live in a queue
  int            ph = 0;
  int            m_idx = 0;
  logic          m_clear = 1'b0;
  logic [DW-1:0] q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      ph = 0; m_clear = 1'b0; q.delete();
    end else begin
      m_clear = 1'b0;
      case (ph)
        0: if (start) begin
          q.delete();
          for (int k = 0; k < NP; k++) q.push_back(pe_results[k*DW +: DW]);
          m_idx = 0; m_clear = 1'b1; ph = 1;
        end
        1: if (out_ready) begin
          void'(q.pop_front());
          m_idx++;
          if (q.size() == 0) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  // Activity log of the DUT, compared against literals by the directed tests
  logic [DW-1:0] beat_data[$];
  int            beat_idx[$];
  int clear_cnt, last_clear_cyc, done_cnt, last_done_cyc, last_busy_cyc, last_cnt;
  logic [DW-1:0] last_data;

  task automatic clear_log();
    beat_data.delete(); beat_idx.delete();
    clear_cnt = 0; last_clear_cyc = -1; done_cnt = 0; last_done_cyc = -1;
    last_busy_cyc = -1; last_cnt = 0; last_data = '0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      ph = 0; m_clear = 1'b0; q.delete();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_clear", pe_clear, 0);
      chk("rst_done", done, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
    end else begin
      chk("m_busy", busy, ph != 0);
      chk("m_valid", out_valid, ph == 1);
      chk("m_clear", pe_clear, m_clear);
      chk("m_done", done, ph == 2);
      if (ph == 1) begin
        chk("m_data", out_data, q[0]);
        chk("m_index", out_index, m_idx);
        chk("m_last", out_last, q.size() == 1);
      end
    end
    if (pe_clear) begin clear_cnt++; last_clear_cyc = cyc; end
    if (done) begin done_cnt++; last_done_cyc = cyc; end
    if (busy) last_busy_cyc = cyc;
    if (out_valid && out_ready) begin
      beat_data.push_back(out_data);
      beat_idx.push_back(int'(out_index));
      if (out_last) begin last_cnt++; last_data = out_data; end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  int e;

  task automatic run_start(input logic [31:0] data);
    pe_results = data;
    start = 1'b1;
    e = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_stream(input string tag, input logic [31:0] word);
    chk({tag, "_nbeats"}, beat_data.size(), 4);
    for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
      chk({tag, "_beat"}, beat_data[i], word[i*8 +: 8]);
      chk({tag, "_idx"}, beat_idx[i], i);
    end
  endtask

  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    clear_log();
    tick(2);
    chk("reset_valid", out_valid, 0);
    chk("reset_index", out_index, 0);
    reset = 1'b0;
    tick(1);

    // basic drain with ready held high
    clear_log();
    out_ready = 1'b1;
    run_start(32'h04_03_02_01);
    tick(8);
    check_stream("t1", 32'h04_03_02_01);
    chk("t1_clear_cnt", clear_cnt, 1);
    chk("t1_clear_time", last_clear_cyc - e, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_time", last_done_cyc - e, 5);
    chk("t1_busy_end", last_busy_cyc - e, 5);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_last_data", last_data, 8'h04);

    // backpressure
    clear_log();
    run_start(32'h04_03_02_01);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      tick(1);
    end
    out_ready = 1'b1;
    tick(4);
    check_stream("t2", 32'h04_03_02_01);
    chk("t2_done_time", last_done_cyc - e, 8);
    chk("t2_done_cnt", done_cnt, 1);

    // capture isolation
    clear_log();
    run_start(32'h04_03_02_01);
    pe_results = 32'hFF_FF_FF_FF;
    tick(8);
    check_stream("t3", 32'h04_03_02_01);

    // start ignored during SEND and during the done cycle
    clear_log();
    run_start(32'h04_03_02_01);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    check_stream("t4", 32'h04_03_02_01);
    chk("t4_clear_cnt", clear_cnt, 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy_end", last_busy_cyc - e, 5);

    // reset after the second beat, then a fresh drain
    clear_log();
    run_start(32'h04_03_02_01);
    tick(2);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_done", done, 0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("t5_partial_beats", beat_data.size(), 2);
    chk("t5_no_done", done_cnt, 0);
    clear_log();
    run_start(32'h80_7F_00_FF);
    tick(8);
    check_stream("t5", 32'h80_7F_00_FF);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_last_data", last_data, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
